// File: rtl/xface_tx_pad_pkg.sv
// Shared types and helpers for the xface transmit pad stage: FSM states,
// MIN_LEN legal range, eop-word byte masking and mod encode/decode.
package xface_tx_pad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2
  } state_e;

  localparam int unsigned MIN_LEN_LO = 16;
  localparam int unsigned MIN_LEN_HI = 120;

  // mod 0 means a full eight-byte word
  function automatic logic [3:0] mod_dec(input logic [2:0] mod);
    return (mod == 3'd0) ? 4'd8 : {1'b0, mod};
  endfunction

  function automatic logic [2:0] mod_enc(input logic [7:0] nbytes);
    return 3'(nbytes);
  endfunction

  // Ones over the bytes that carry packet data in an eop word
  function automatic logic [63:0] keep_mask(input logic [2:0] mod);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < 32'(mod_dec(mod))) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Fill value over the bytes beyond mod, zero elsewhere
  function automatic logic [63:0] byte_mask(input logic [2:0] mod, input logic [7:0] pad_byte);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i >= 32'(mod_dec(mod))) m[i*8 +: 8] = pad_byte;
    end
    return m;
  endfunction

endpackage

// File: rtl/xface_tx_pad_if.sv
// Input-side xface packet bus: 64-bit word, eop byte count, framing flags, val/ready handshake.
interface xface_tx_pad_if;
  logic [63:0] data;
  logic [2:0]  mod;
  logic        sop;
  logic        eop;
  logic        val;
  logic        ready;

  modport master (output data, mod, sop, eop, val, input ready);
  modport slave  (input data, mod, sop, eop, val, output ready);
endinterface

// File: rtl/xface_tx_pad.sv
// Pads short xface frames up to MIN_LEN bytes ahead of the GMII TX converter.
// Optional TX_PAD_STAT_EN adds saturating padded-packet / framing-error counters.
module xface_tx_pad
  import xface_tx_pad_pkg::*;
#(
  parameter int unsigned MIN_LEN  = 60,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic          clk_sys_i,
  input  logic          rst_sys_n_i,
  xface_tx_pad_if.slave pkt_rx,
  input  logic          tx_fifo_full_i,
  output logic [63:0]   pkt_tx_data_o,
  output logic [2:0]    pkt_tx_mod_o,
  output logic          pkt_tx_sop_o,
  output logic          pkt_tx_eop_o,
  output logic          pkt_tx_val_o,
  output logic          proto_err_o,
  output logic [15:0]   pad_cnt_o,
  output logic [15:0]   err_cnt_o
);

  localparam logic [7:0]  MIN_LEN_B = 8'(MIN_LEN);
  localparam logic [63:0] PAD_WORD  = {8{PAD_BYTE}};

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        hold_vld_q, hold_vld_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [2:0]  hold_mod_q, hold_mod_d;
  logic        hold_eop_q, hold_eop_d;
  logic [63:0] tx_data_q, tx_data_d;
  logic [2:0]  tx_mod_q, tx_mod_d;
  logic        tx_sop_q, tx_sop_d;
  logic        tx_eop_q, tx_eop_d;
  logic        tx_val_q, tx_val_d;
  logic        err_q, err_d;

  logic        ready, acc;
  logic        in_go, in_sop, in_eop;
  logic [2:0]  in_mod;
  logic [63:0] in_data;
  logic [7:0]  sum, rem, cnt_inc;
  logic [6:0]  cnt_sat;
  logic        short_eop, eop_go;

  assign ready        = !tx_fifo_full_i && (state_q != PAD) && !hold_vld_q;
  assign pkt_rx.ready = ready;
  assign acc          = pkt_rx.val && ready;

  // A held sop word (left over from a mid-packet sop) takes priority over the bus
  always_comb begin
    if (hold_vld_q) begin
      in_data = hold_data_q;
      in_mod  = hold_mod_q;
      in_sop  = 1'b1;
      in_eop  = hold_eop_q;
      in_go   = !tx_fifo_full_i;
    end else begin
      in_data = pkt_rx.data;
      in_mod  = pkt_rx.mod;
      in_sop  = pkt_rx.sop;
      in_eop  = pkt_rx.eop;
      in_go   = acc;
    end
  end

  assign sum       = {1'b0, cnt_q} + {4'd0, mod_dec(in_mod)};
  assign rem       = MIN_LEN_B - {1'b0, cnt_q};
  assign cnt_inc   = {1'b0, cnt_q} + 8'd8;
  assign cnt_sat   = (cnt_inc >= MIN_LEN_B) ? MIN_LEN_B[6:0] : cnt_inc[6:0];
  assign short_eop = sum < MIN_LEN_B;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_mod_d  = hold_mod_q;
    hold_eop_d  = hold_eop_q;
    tx_data_d   = tx_data_q;
    tx_mod_d    = '0;
    tx_sop_d    = 1'b0;
    tx_eop_d    = 1'b0;
    tx_val_d    = 1'b0;
    err_d       = 1'b0;
    eop_go      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_go) begin
          hold_vld_d = 1'b0;
          if (!in_sop) begin
            err_d = 1'b1;
          end else begin
            tx_val_d  = 1'b1;
            tx_sop_d  = 1'b1;
            tx_data_d = in_data;
            if (in_eop) begin
              eop_go = 1'b1;
            end else begin
              cnt_d   = cnt_sat;
              state_d = PASS;
            end
          end
        end
      end
      PASS: begin
        if (in_go) begin
          if (in_sop) begin
            // Close the broken packet now; the new sop word waits in the hold register
            err_d       = 1'b1;
            hold_vld_d  = 1'b1;
            hold_data_d = in_data;
            hold_mod_d  = in_mod;
            hold_eop_d  = in_eop;
            tx_val_d    = 1'b1;
            tx_eop_d    = 1'b1;
            tx_data_d   = PAD_WORD;
            cnt_d       = '0;
            state_d     = IDLE;
          end else begin
            tx_val_d  = 1'b1;
            tx_data_d = in_data;
            if (in_eop) eop_go = 1'b1;
            else        cnt_d  = cnt_sat;
          end
        end
      end
      PAD: begin
        if (!tx_fifo_full_i) begin
          tx_val_d  = 1'b1;
          tx_data_d = PAD_WORD;
          if (rem <= 8'd8) begin
            tx_eop_d = 1'b1;
            tx_mod_d = mod_enc(rem);
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared eop handling for IDLE sop+eop and PASS eop words
    if (eop_go) begin
      if (!short_eop) begin
        tx_eop_d = 1'b1;
        tx_mod_d = in_mod;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        tx_data_d = (in_data & keep_mask(in_mod)) | byte_mask(in_mod, PAD_BYTE);
        if (rem <= 8'd8) begin
          tx_eop_d = 1'b1;
          tx_mod_d = mod_enc(rem);
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d   = cnt_sat;
          state_d = PAD;
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_mod_q  <= '0;
      hold_eop_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_mod_q    <= '0;
      tx_sop_q    <= 1'b0;
      tx_eop_q    <= 1'b0;
      tx_val_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_mod_q  <= hold_mod_d;
      hold_eop_q  <= hold_eop_d;
      tx_data_q   <= tx_data_d;
      tx_mod_q    <= tx_mod_d;
      tx_sop_q    <= tx_sop_d;
      tx_eop_q    <= tx_eop_d;
      tx_val_q    <= tx_val_d;
      err_q       <= err_d;
    end
  end

  assign pkt_tx_data_o = tx_data_q;
  assign pkt_tx_mod_o  = tx_mod_q;
  assign pkt_tx_sop_o  = tx_sop_q;
  assign pkt_tx_eop_o  = tx_eop_q;
  assign pkt_tx_val_o  = tx_val_q;
  assign proto_err_o   = err_q;

`ifdef TX_PAD_STAT_EN
  logic        pad_evt;
  logic [15:0] pad_cnt_q, pad_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  assign pad_evt = eop_go && short_eop;

  always_comb begin
    pad_cnt_d = pad_cnt_q;
    err_cnt_d = err_cnt_q;
    if (pad_evt && (pad_cnt_q != '1)) pad_cnt_d = pad_cnt_q + 16'd1;
    if (err_d   && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_n_i) begin
    if (!rst_sys_n_i) begin
      pad_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pad_cnt_q <= pad_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pad_cnt_o = pad_cnt_q;
  assign err_cnt_o = err_cnt_q;
`else
  assign pad_cnt_o = '0;
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_xface_tx_pad.sv
// Directed, table-driven bench for xface_tx_pad (MIN_LEN 60, PAD_BYTE 00).
module tb_xface_tx_pad;

  typedef struct {
    logic        iv, isop, ieop;
    logic [2:0]  imod;
    logic [63:0] idata;
    logic        ifull;
    logic        xrdy, xval, xsop, xeop;
    logic [2:0]  xmod;
    logic [63:0] xdata;
    logic        xerr;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [63:0] Z = 64'h0;
`ifdef TX_PAD_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        full;
  logic [63:0] tx_data;
  logic [2:0]  tx_mod;
  logic        tx_sop, tx_eop, tx_val, err;
  logic [15:0] pad_cnt, err_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  xface_tx_pad_if rx_if ();

  xface_tx_pad #(.MIN_LEN(60), .PAD_BYTE(8'h00)) dut (
    .clk_sys_i     (clk),
    .rst_sys_n_i   (rst_n),
    .pkt_rx        (rx_if),
    .tx_fifo_full_i(full),
    .pkt_tx_data_o (tx_data),
    .pkt_tx_mod_o  (tx_mod),
    .pkt_tx_sop_o  (tx_sop),
    .pkt_tx_eop_o  (tx_eop),
    .pkt_tx_val_o  (tx_val),
    .proto_err_o   (err),
    .pad_cnt_o     (pad_cnt),
    .err_cnt_o     (err_cnt)
  );

  always #5 clk = ~clk;

  // Word k carries bytes 8k..8k+7, byte 0 in [7:0]
  function automatic logic [63:0] W(input int k);
    return 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
  endfunction

  function automatic vec_t r(input logic iv, isop, ieop, input logic [2:0] imod,
                             input logic [63:0] idata, input logic ifull,
                             input logic xrdy, xval, xsop, xeop, input logic [2:0] xmod,
                             input logic [63:0] xdata, input logic xerr);
    vec_t v;
    v.iv = iv; v.isop = isop; v.ieop = ieop; v.imod = imod; v.idata = idata; v.ifull = ifull;
    v.xrdy = xrdy; v.xval = xval; v.xsop = xsop; v.xeop = xeop; v.xmod = xmod;
    v.xdata = xdata; v.xerr = xerr;
    return v;
  endfunction

  // Idle input row with expected outputs
  function automatic vec_t o(input logic xrdy, xval, xsop, xeop, input logic [2:0] xmod,
                             input logic [63:0] xdata, input logic xerr);
    return r(L, L, L, 3'd0, Z, L, xrdy, xval, xsop, xeop, xmod, xdata, xerr);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    rx_if.val  = v.iv;
    rx_if.sop  = v.isop;
    rx_if.eop  = v.ieop;
    rx_if.mod  = v.imod;
    rx_if.data = v.idata;
    full       = v.ifull;
    #1;
    chk({tag, " ready"}, 64'(rx_if.ready), 64'(v.xrdy));
    chk({tag, " val"},   64'(tx_val), 64'(v.xval));
    chk({tag, " err"},   64'(err), 64'(v.xerr));
    if (v.xval) begin
      chk({tag, " sop"},  64'(tx_sop), 64'(v.xsop));
      chk({tag, " eop"},  64'(tx_eop), 64'(v.xeop));
      chk({tag, " mod"},  64'(tx_mod), 64'(v.xmod));
      chk({tag, " data"}, tx_data, v.xdata);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp_pad, input int exp_err);
    chk({tag, " pad_cnt"}, 64'(pad_cnt), 64'(STAT * exp_pad));
    chk({tag, " err_cnt"}, 64'(err_cnt), 64'(STAT * exp_err));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rst val"},   64'(tx_val), 64'd0);
    chk({tag, " rst data"},  tx_data, 64'd0);
    chk({tag, " rst sop"},   64'(tx_sop), 64'd0);
    chk({tag, " rst eop"},   64'(tx_eop), 64'd0);
    chk({tag, " rst mod"},   64'(tx_mod), 64'd0);
    chk({tag, " rst err"},   64'(err), 64'd0);
    chk({tag, " rst ready"}, 64'(rx_if.ready), 64'd1);
    chk_cnt(tag, 0, 0);
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; full = 1'b0;
    rx_if.val = 1'b0; rx_if.sop = 1'b0; rx_if.eop = 1'b0; rx_if.mod = '0; rx_if.data = '0;
    #12;
    chk_reset("init");
    @(negedge clk);
    rst_n = 1'b1;

    // 64-byte packet: 8 full words pass unchanged one cycle late
    tbl.push_back(r(H, H, L, 3'd0, W(0), L, H, L, L, L, 3'd0, Z, L));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(r(H, L, (k == 7), 3'd0, W(k), L, H, H, (k == 1), L, 3'd0, W(k-1), L));
    tbl.push_back(o(H, H, L, H, 3'd0, W(7), L));
    tbl.push_back(o(H, L, L, L, 3'd0, Z, L));
    // 14-byte packet: padded to 60 bytes over 8 output words
    tbl.push_back(r(H, H, L, 3'd0, W(10), L, H, L, L, L, 3'd0, Z, L));
    tbl.push_back(r(H, L, H, 3'd6, W(11), L, H, H, H, L, 3'd0, 64'h5756555453525150, L));
    tbl.push_back(o(L, H, L, L, 3'd0, 64'h00005D5C5B5A5958, L));
    for (int k = 0; k < 5; k++) tbl.push_back(o(L, H, L, L, 3'd0, Z, L));
    tbl.push_back(o(H, H, L, H, 3'd4, Z, L));
    tbl.push_back(o(H, L, L, L, 3'd0, Z, L));
    // 57-byte packet: last word extended to mod 4, no pad words
    tbl.push_back(r(H, H, L, 3'd0, W(20), L, H, L, L, L, 3'd0, Z, L));
    for (int k = 21; k <= 27; k++)
      tbl.push_back(r(H, L, (k == 27), (k == 27) ? 3'd1 : 3'd0, W(k), L,
                      H, H, (k == 21), L, 3'd0, W(k-1), L));
    tbl.push_back(o(H, H, L, H, 3'd4, 64'h00000000000000D8, L));
    tbl.push_back(o(H, L, L, L, 3'd0, Z, L));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));
    chk_cnt("tbl", 2, 0);

    // Backpressure for 3 cycles while the third pad word is due
    step(r(H, H, L, 3'd0, W(4), L, H, L, L, L, 3'd0, Z, L), "bp0");
    step(r(H, L, H, 3'd6, W(5), L, H, H, H, L, 3'd0, W(4), L), "bp1");
    step(o(L, H, L, L, 3'd0, 64'h00002D2C2B2A2928, L), "bp2");
    step(o(L, H, L, L, 3'd0, Z, L), "bp3");
    step(r(L, L, L, 3'd0, Z, H, L, H, L, L, 3'd0, Z, L), "bp4");
    step(r(L, L, L, 3'd0, Z, H, L, L, L, L, 3'd0, Z, L), "bp5");
    step(r(L, L, L, 3'd0, Z, H, L, L, L, L, 3'd0, Z, L), "bp6");
    step(o(L, L, L, L, 3'd0, Z, L), "bp7");
    for (int k = 8; k <= 10; k++) step(o(L, H, L, L, 3'd0, Z, L), $sformatf("bp%0d", k));
    step(o(H, H, L, H, 3'd4, Z, L), "bp11");
    step(o(H, L, L, L, 3'd0, Z, L), "bp12");
    chk_cnt("bp", 3, 0);

    // sop mid-packet: closing word, then the held sop word restarts a packet
    step(r(H, H, L, 3'd0, W(1), L, H, L, L, L, 3'd0, Z, L), "ps0");
    step(r(H, L, L, 3'd0, W(2), L, H, H, H, L, 3'd0, W(1), L), "ps1");
    step(r(H, H, L, 3'd0, W(12), L, H, H, L, L, 3'd0, W(2), L), "ps2");
    step(o(L, H, L, H, 3'd0, Z, H), "ps3");
    step(r(H, L, L, 3'd0, W(13), L, H, H, H, L, 3'd0, W(12), L), "ps4");
    for (int k = 14; k <= 19; k++)
      step(r(H, L, (k == 19), 3'd0, W(k), L, H, H, L, L, 3'd0, W(k-1), L), $sformatf("ps%0d", k - 9));
    step(o(H, H, L, H, 3'd0, W(19), L), "ps11");
    // val without sop in IDLE is dropped
    step(r(H, L, L, 3'd0, W(20), L, H, L, L, L, 3'd0, Z, L), "ps12");
    step(o(H, L, L, L, 3'd0, Z, H), "ps13");
    step(o(H, L, L, L, 3'd0, Z, L), "ps14");
    chk_cnt("ps", 3, 2);

    // Reset while padding: outputs clear immediately, next packet is clean
    step(r(H, H, L, 3'd0, W(4), L, H, L, L, L, 3'd0, Z, L), "rs0");
    step(r(H, L, H, 3'd6, W(5), L, H, H, H, L, 3'd0, W(4), L), "rs1");
    step(o(L, H, L, L, 3'd0, 64'h00002D2C2B2A2928, L), "rs2");
    rst_n = 1'b0;
    #1;
    chk_reset("rs");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("rr%0d", i));
    chk_cnt("rr", 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
